// File: rtl/alu_defs_pkg.sv
// Shared encodings for the ALU main-control classes, R-type opcodes and the 4-bit ALU control codes.
// Used by both the control decoder and the execution unit.
package alu_defs_pkg;

  localparam logic [1:0] ALUOP_LDST    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH  = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE   = 2'b10;
  localparam logic [1:0] ALUOP_ILLEGAL = 2'b11;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;
  localparam logic [10:0] OPC_LSL = 11'b11010011011;
  localparam logic [10:0] OPC_LSR = 11'b11010011010;
  localparam logic [10:0] OPC_MUL = 11'b10011011000;
  // ADDI carries an immediate bit in opcode[0], so only the upper ten bits identify it
  localparam logic [9:0]  OPC_ADDI_HI = 10'b1001000100;

  localparam logic [3:0] CTRL_AND     = 4'b0000;
  localparam logic [3:0] CTRL_ORR     = 4'b0001;
  localparam logic [3:0] CTRL_ADD     = 4'b0010;
  localparam logic [3:0] CTRL_LSL     = 4'b0011;
  localparam logic [3:0] CTRL_LSR     = 4'b0100;
  localparam logic [3:0] CTRL_SUB     = 4'b0110;
  localparam logic [3:0] CTRL_PASSB   = 4'b0111;
  localparam logic [3:0] CTRL_MUL     = 4'b1000;
  localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    HOLD = 2'b10
  } exec_state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control: maps the main-control class and R-type opcode to a 4-bit ALU code.
// Anything not recognised (including MUL when the multiplier is not built) is flagged illegal.
module alu_ctrl_decode
  import alu_defs_pkg::*;
#(
  parameter int MUL_EN = 1
) (
  input  logic [1:0]  alu_op,
  input  logic [10:0] opcode,
  output logic [3:0]  ctrl,
  output logic        illegal
);

  always_comb begin
    ctrl    = CTRL_ILLEGAL;
    illegal = 1'b1;
    case (alu_op)
      ALUOP_LDST: begin
        ctrl    = CTRL_ADD;
        illegal = 1'b0;
      end
      ALUOP_BRANCH: begin
        ctrl    = CTRL_PASSB;
        illegal = 1'b0;
      end
      ALUOP_RTYPE: begin
        if (opcode[10:1] == OPC_ADDI_HI) begin
          ctrl    = CTRL_ADD;
          illegal = 1'b0;
        end else begin
          case (opcode)
            OPC_ADD: begin ctrl = CTRL_ADD; illegal = 1'b0; end
            OPC_SUB: begin ctrl = CTRL_SUB; illegal = 1'b0; end
            OPC_AND: begin ctrl = CTRL_AND; illegal = 1'b0; end
            OPC_ORR: begin ctrl = CTRL_ORR; illegal = 1'b0; end
            OPC_LSL: begin ctrl = CTRL_LSL; illegal = 1'b0; end
            OPC_LSR: begin ctrl = CTRL_LSR; illegal = 1'b0; end
            OPC_MUL: begin
              if (MUL_EN != 0) begin
                ctrl    = CTRL_MUL;
                illegal = 1'b0;
              end
            end
            default: begin
              ctrl    = CTRL_ILLEGAL;
              illegal = 1'b1;
            end
          endcase
        end
      end
      ALUOP_ILLEGAL: begin
        ctrl    = CTRL_ILLEGAL;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_seq.sv
// Sequential ALU execution unit: single-cycle ops with a registered output stage, plus an
// iterative shift-add multiplier, behind valid/ready handshakes on both sides.
module alu_exec_seq
  import alu_defs_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [10:0]      opcode,
  input  logic [5:0]       shamt,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [3:0]       ctrl,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH);

  exec_state_e      state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] mulAcc_q, mulAcc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    mulCnt_q, mulCnt_d;
  logic             readyEn_q;

  logic [3:0]       decCtrl;
  logic             decIllegal;
  logic [WIDTH-1:0] aluRes;
  logic [WIDTH-1:0] mulSum;
  logic [6:0]       shiftAmt;
  logic             accept;

  alu_ctrl_decode #(.MUL_EN(MUL_EN)) u_decode (
    .alu_op  (alu_op),
    .opcode  (opcode),
    .ctrl    (decCtrl),
    .illegal (decIllegal)
  );

  always_comb begin
    shiftAmt = 7'(shamt) % 7'(WIDTH);
    aluRes   = '0;
    case (decCtrl)
      CTRL_ADD:   aluRes = op_a + op_b;
      CTRL_SUB:   aluRes = op_a - op_b;
      CTRL_AND:   aluRes = op_a & op_b;
      CTRL_ORR:   aluRes = op_a | op_b;
      CTRL_LSL:   aluRes = op_a << shiftAmt;
      CTRL_LSR:   aluRes = op_a >> shiftAmt;
      CTRL_PASSB: aluRes = op_b;
      default:    aluRes = '0;
    endcase
  end

  // readyEn_q keeps in_ready low through reset and until the first edge after release
  assign in_ready  = readyEn_q && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign result    = result_q;
  assign zero      = zero_q;
  assign ctrl      = ctrl_q;
  assign illegal   = illegal_q;
  assign mulSum    = mulAcc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    mulAcc_d  = mulAcc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    mulCnt_d  = mulCnt_q;

    case (state_q)
      MUL: begin
        mulAcc_d = mulSum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        mulCnt_d = mulCnt_q + 1'b1;
        if (mulCnt_q == CW'(WIDTH - 1)) begin
          state_d   = HOLD;
          result_d  = mulSum;
          zero_d    = (mulSum == '0);
          ctrl_d    = CTRL_MUL;
          illegal_d = 1'b0;
          mulCnt_d  = '0;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = state_q;
    endcase

    // A new request (only possible in IDLE or a draining HOLD) overrides the drain to IDLE
    if (accept) begin
      if ((decCtrl == CTRL_MUL) && !decIllegal) begin
        state_d  = MUL;
        mulAcc_d = '0;
        mcand_d  = op_a;
        mplier_d = op_b;
        mulCnt_d = '0;
      end else begin
        state_d   = HOLD;
        result_d  = aluRes;
        zero_d    = (aluRes == '0);
        ctrl_d    = decCtrl;
        illegal_d = decIllegal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b1;
      ctrl_q    <= CTRL_AND;
      illegal_q <= 1'b0;
      mulAcc_q  <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      mulCnt_q  <= '0;
      readyEn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      mulAcc_q  <= mulAcc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      mulCnt_q  <= mulCnt_d;
      readyEn_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed self-checking bench for alu_exec_seq; a second instance built with MUL_EN=0
// shares the inputs to cover the illegal-MUL decode.
module tb_alu_exec_seq;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [10:0]      opcode;
  logic [5:0]       shamt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [3:0]       ctrl;
  logic             illegal;

  logic             nmInReady;
  logic             nmOutValid;
  logic [WIDTH-1:0] nmResult;
  logic             nmZero;
  logic [3:0]       nmCtrl;
  logic             nmIllegal;

  int compareCount  = 0;
  int mismatchCount = 0;

  always #5 clk = ~clk;

  alu_exec_seq #(.WIDTH(WIDTH), .MUL_EN(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .opcode    (opcode),
    .shamt     (shamt),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .ctrl      (ctrl),
    .illegal   (illegal)
  );

  alu_exec_seq #(.WIDTH(WIDTH), .MUL_EN(0)) dutNoMul (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (nmInReady),
    .alu_op    (alu_op),
    .opcode    (opcode),
    .shamt     (shamt),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (nmOutValid),
    .out_ready (out_ready),
    .result    (nmResult),
    .zero      (nmZero),
    .ctrl      (nmCtrl),
    .illegal   (nmIllegal)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one request for a single clock edge, then returns #1 after that edge
  task automatic applyStimulus(input logic [1:0] aluOp, input logic [10:0] opc, input logic [5:0] sh,
                               input logic [63:0] a, input logic [63:0] b);
    alu_op   = aluOp;
    opcode   = opc;
    shamt    = sh;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int waited;
    int lowCycles;
    int pulses;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_op    = 2'b00;
    opcode    = '0;
    shamt     = '0;
    op_a      = '0;
    op_b      = '0;

    #12;
    checkOutput("rstInReady", in_ready, 0);
    checkOutput("rstOutValid", out_valid, 0);
    checkOutput("rstResult", result, 0);
    checkOutput("rstZero", zero, 1);
    checkOutput("rstCtrl", ctrl, 4'b0000);
    checkOutput("rstIllegal", illegal, 0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("readyBeforeEdge", in_ready, 0);
    @(posedge clk);
    #1;
    checkOutput("readyAfterEdge", in_ready, 1);

    applyStimulus(2'b10, 11'b11001011000, 6'd0, 64'd10, 64'd3);
    checkOutput("subValid", out_valid, 1);
    checkOutput("subResult", result, 64'd7);
    checkOutput("subCtrl", ctrl, 4'b0110);
    checkOutput("subZero", zero, 0);

    applyStimulus(2'b00, 11'b11111000010, 6'd0, 64'h100, 64'h8);
    checkOutput("ldurResult", result, 64'h108);
    checkOutput("ldurCtrl", ctrl, 4'b0010);

    applyStimulus(2'b01, 11'b10110100000, 6'd0, 64'h55, 64'h0);
    checkOutput("passResult", result, 64'h0);
    checkOutput("passZero", zero, 1);
    checkOutput("passCtrl", ctrl, 4'b0111);
    checkOutput("passIllegal", illegal, 0);

    applyStimulus(2'b10, 11'b10001010000, 6'd0, 64'hFF00, 64'h0FF0);
    checkOutput("andResult", result, 64'h0F00);
    checkOutput("andCtrl", ctrl, 4'b0000);

    applyStimulus(2'b10, 11'b10010001001, 6'd0, 64'd100, 64'd23);
    checkOutput("addiResult", result, 64'd123);
    checkOutput("addiCtrl", ctrl, 4'b0010);

    applyStimulus(2'b10, 11'b10001011000, 6'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    checkOutput("addWrap", result, 64'd1);

    applyStimulus(2'b10, 11'b11001011000, 6'd0, 64'd3, 64'd10);
    checkOutput("subNeg", result, 64'hFFFF_FFFF_FFFF_FFF9);

    applyStimulus(2'b10, 11'b11010011011, 6'd63, 64'd1, 64'd0);
    checkOutput("lslResult", result, 64'h8000_0000_0000_0000);
    checkOutput("lslCtrl", ctrl, 4'b0011);

    applyStimulus(2'b10, 11'b11010011010, 6'd63, 64'h8000_0000_0000_0000, 64'd0);
    checkOutput("lsrResult", result, 64'd1);
    checkOutput("lsrCtrl", ctrl, 4'b0100);

    applyStimulus(2'b10, 11'b11111111111, 6'd0, 64'd5, 64'd6);
    checkOutput("haltValid", out_valid, 1);
    checkOutput("haltIllegal", illegal, 1);
    checkOutput("haltResult", result, 0);
    checkOutput("haltZero", zero, 1);
    checkOutput("haltCtrl", ctrl, 4'b1111);

    applyStimulus(2'b11, 11'b10001011000, 6'd0, 64'd5, 64'd6);
    checkOutput("op11Illegal", illegal, 1);
    checkOutput("op11Ctrl", ctrl, 4'b1111);

    applyStimulus(2'b10, 11'b10011011000, 6'd0, 64'd7, 64'd6);
    op_a   = 64'hDEAD;
    op_b   = 64'hBEEF;
    alu_op = 2'b00;
    checkOutput("noMulValid", nmOutValid, 1);
    checkOutput("noMulIllegal", nmIllegal, 1);
    checkOutput("noMulCtrl", nmCtrl, 4'b1111);
    checkOutput("noMulResult", nmResult, 0);
    waited    = 0;
    lowCycles = 0;
    while (!out_valid && waited < 200) begin
      if (!in_ready) lowCycles++;
      @(posedge clk);
      #1;
      waited++;
    end
    checkOutput("mulLatency", waited, 64);
    checkOutput("mulReadyLow", lowCycles, 64);
    checkOutput("mulResult", result, 64'd42);
    checkOutput("mulCtrl", ctrl, 4'b1000);
    checkOutput("mulIllegal", illegal, 0);

    applyStimulus(2'b10, 11'b10001011000, 6'd0, 64'd5, 64'd9);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("holdResult", result, 64'd14);
      checkOutput("holdReady", in_ready, 0);
      checkOutput("holdValid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    alu_op    = 2'b10;
    opcode    = 11'b10101010000;
    op_a      = 64'hF0;
    op_b      = 64'h0F;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("drainReady", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("orrValid", out_valid, 1);
    checkOutput("orrResult", result, 64'hFF);
    checkOutput("orrCtrl", ctrl, 4'b0001);

    applyStimulus(2'b10, 11'b10011011000, 6'd0, 64'd7, 64'd6);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abortValid", out_valid, 0);
    checkOutput("abortResult", result, 0);
    checkOutput("abortZero", zero, 1);
    checkOutput("abortCtrl", ctrl, 4'b0000);
    checkOutput("abortReady", in_ready, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    checkOutput("abortNoPulse", pulses, 0);

    applyStimulus(2'b10, 11'b10001011000, 6'd0, 64'd20, 64'd22);
    checkOutput("postRstValid", out_valid, 1);
    checkOutput("postRstResult", result, 64'd42);
    checkOutput("postRstCtrl", ctrl, 4'b0010);

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
